// File: rtl/ecdsa_arg_dma_engine.sv
// Command sequencer: pointer-table gather over DMA, arithmetic core run, pointer-table scatter of results.
// Optional DMA watchdog is built only when DMA_TIMEOUT_EN is defined.
module ecdsa_arg_dma_engine #(
    parameter int DATA_W     = 381,
    parameter int MAX_ARGC_I = 7,
    parameter int MAX_ARGC_O = 3,
    parameter int TIMEOUT_W  = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  cmd,
    input  logic [31:0]                  tbl_in_addr,
    input  logic [31:0]                  argc_i,
    input  logic [31:0]                  tbl_out_addr,
    input  logic [31:0]                  argc_o,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   err_code,
    output logic [31:0]                  dma_rx_address,
    output logic                         dma_rx_start,
    input  logic [DATA_W-1:0]            dma_rx_data,
    output logic [31:0]                  dma_tx_address,
    output logic                         dma_tx_start,
    output logic [DATA_W-1:0]            dma_tx_data,
    input  logic                         dma_done,
    input  logic                         dma_idle,
    input  logic                         dma_error,
    output logic                         core_start,
    output logic [31:0]                  core_op,
    output logic [MAX_ARGC_I*DATA_W-1:0] core_args,
    input  logic                         core_done,
    input  logic [MAX_ARGC_O*DATA_W-1:0] core_res
);

    localparam int N_PTR = (MAX_ARGC_I > MAX_ARGC_O) ? MAX_ARGC_I : MAX_ARGC_O;

    typedef enum logic [3:0] {
        IDLE, TI_REQ, TI_WAIT, ARG_REQ, ARG_WAIT, CORE_START, CORE_WAIT,
        TO_REQ, TO_WAIT, TX_REQ, TX_WAIT, DONE, ERROR
    } state_t;

    state_t                       state_q, state_d;
    logic [3:0]                   k_q, argc_i_q, argc_o_q;
    logic [31:0]                  op_q, rx_addr_q, tx_addr_q;
    logic [MAX_ARGC_I*32-1:0]     ptr_i_q;
    logic [MAX_ARGC_O*32-1:0]     ptr_o_q;
    logic [MAX_ARGC_I*DATA_W-1:0] args_q;
    logic [MAX_ARGC_O*DATA_W-1:0] res_q;
    logic [DATA_W-1:0]            tx_data_q;
    logic [1:0]                   err_code_q;
    logic                         start_q;
    logic [N_PTR*32-1:0]          ptr_tbl;
    logic in_req, in_wait, req_go, xfer_ok, xfer_err, tmo_hit, bad_argc, last_arg, last_res;

    // Pointer j sits MSB-first in the beat: entry 0 occupies the top 32 bits.
    function automatic logic [N_PTR*32-1:0] unpack_ptrs(input logic [DATA_W-1:0] beat);
        logic [N_PTR*32-1:0] p;
        for (int j = 0; j < N_PTR; j++) p[j*32 +: 32] = beat[DATA_W-1-32*j -: 32];
        return p;
    endfunction

    assign ptr_tbl  = unpack_ptrs(dma_rx_data);
    assign in_req   = (state_q == TI_REQ) || (state_q == ARG_REQ) || (state_q == TO_REQ) || (state_q == TX_REQ);
    assign in_wait  = (state_q == TI_WAIT) || (state_q == ARG_WAIT) || (state_q == TO_WAIT) || (state_q == TX_WAIT);
    assign req_go   = in_req && dma_idle;
    assign xfer_ok  = in_wait && dma_done && !dma_error;
    assign xfer_err = in_wait && dma_done && dma_error;
    assign bad_argc = (argc_i == 32'd0) || (argc_i > 32'(MAX_ARGC_I)) ||
                      (argc_o == 32'd0) || (argc_o > 32'(MAX_ARGC_O));
    assign last_arg = (k_q == argc_i_q - 4'd1);
    assign last_res = (k_q == argc_o_q - 4'd1);

`ifdef DMA_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_q;

    always_ff @(posedge clk) begin
        if (reset)        tmo_q <= '0;
        else if (req_go)  tmo_q <= '0;
        else if (in_wait) tmo_q <= tmo_q + TIMEOUT_W'(1);
    end

    assign tmo_hit = in_wait && !dma_done && (tmo_q == '1);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (cmd != 32'd0) state_d = bad_argc ? ERROR : TI_REQ;
            TI_REQ:     if (dma_idle) state_d = TI_WAIT;
            TI_WAIT:    if (xfer_ok) state_d = ARG_REQ;
            ARG_REQ:    if (dma_idle) state_d = ARG_WAIT;
            ARG_WAIT:   if (xfer_ok) state_d = last_arg ? CORE_START : ARG_REQ;
            CORE_START: state_d = CORE_WAIT;
            CORE_WAIT:  if (core_done) state_d = TO_REQ;
            TO_REQ:     if (dma_idle) state_d = TO_WAIT;
            TO_WAIT:    if (xfer_ok) state_d = TX_REQ;
            TX_REQ:     if (dma_idle) state_d = TX_WAIT;
            TX_WAIT:    if (xfer_ok) state_d = last_res ? DONE : TX_REQ;
            DONE, ERROR: if (cmd == 32'd0) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        if (xfer_err || tmo_hit) state_d = ERROR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q        <= '0;
            argc_i_q   <= '0;
            argc_o_q   <= '0;
            op_q       <= '0;
            rx_addr_q  <= '0;
            tx_addr_q  <= '0;
            ptr_i_q    <= '0;
            ptr_o_q    <= '0;
            args_q     <= '0;
            res_q      <= '0;
            tx_data_q  <= '0;
            err_code_q <= '0;
            start_q    <= 1'b0;
        end else begin
            // start_q marks the first cycle of every *_WAIT state
            start_q <= req_go;
            case (state_q)
                IDLE: if (cmd != 32'd0) begin
                    op_q     <= cmd;
                    argc_i_q <= argc_i[3:0];
                    argc_o_q <= argc_o[3:0];
                    k_q      <= '0;
                    if (bad_argc) err_code_q <= 2'd1;
                end
                TI_REQ:  if (dma_idle) rx_addr_q <= tbl_in_addr;
                ARG_REQ: if (dma_idle) rx_addr_q <= ptr_i_q[int'(k_q)*32 +: 32];
                TO_REQ:  if (dma_idle) rx_addr_q <= tbl_out_addr;
                TX_REQ:  if (dma_idle) begin
                    tx_addr_q <= ptr_o_q[int'(k_q)*32 +: 32];
                    tx_data_q <= res_q[int'(k_q)*DATA_W +: DATA_W];
                end
                TI_WAIT: if (xfer_ok) ptr_i_q <= ptr_tbl[MAX_ARGC_I*32-1:0];
                ARG_WAIT: if (xfer_ok) begin
                    args_q[int'(k_q)*DATA_W +: DATA_W] <= dma_rx_data;
                    if (!last_arg) k_q <= k_q + 4'd1;
                end
                CORE_WAIT: if (core_done) begin
                    res_q <= core_res;
                    k_q   <= '0;
                end
                TO_WAIT: if (xfer_ok) ptr_o_q <= ptr_tbl[MAX_ARGC_O*32-1:0];
                TX_WAIT: if (xfer_ok && !last_res) k_q <= k_q + 4'd1;
                DONE, ERROR: if (cmd == 32'd0) err_code_q <= '0;
                default: ;
            endcase
            if (xfer_err)     err_code_q <= 2'd2;
            else if (tmo_hit) err_code_q <= 2'd3;
        end
    end

    always_comb begin
        busy         = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
        done         = (state_q == DONE);
        err          = (state_q == ERROR);
        dma_rx_start = start_q && ((state_q == TI_WAIT) || (state_q == ARG_WAIT) || (state_q == TO_WAIT));
        dma_tx_start = start_q && (state_q == TX_WAIT);
        core_start   = (state_q == CORE_START);
    end

    assign err_code       = err_code_q;
    assign dma_rx_address = rx_addr_q;
    assign dma_tx_address = tx_addr_q;
    assign dma_tx_data    = tx_data_q;
    assign core_op        = op_q;
    assign core_args      = args_q;

endmodule

// File: tb/tb_ecdsa_arg_dma_engine.sv
// Randomized bench for ecdsa_arg_dma_engine: DMA/core responders plus a transaction-level reference model.
`timescale 1ns/1ps
module tb_ecdsa_arg_dma_engine;
    localparam int DW = 381;
    localparam int MI = 7;
    localparam int MO = 3;
`ifdef DMA_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 20;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [31:0] cmd, tbl_in_addr, argc_i, tbl_out_addr, argc_o;
    logic busy, done, err;
    logic [1:0] err_code;
    logic [31:0] dma_rx_address, dma_tx_address;
    logic dma_rx_start, dma_tx_start;
    logic [DW-1:0] dma_rx_data, dma_tx_data;
    logic dma_done, dma_idle, dma_error, core_start, core_done;
    logic [31:0] core_op;
    logic [MI*DW-1:0] core_args;
    logic [MO*DW-1:0] core_res;

    always #5 clk = ~clk;

    ecdsa_arg_dma_engine #(.DATA_W(DW), .MAX_ARGC_I(MI), .MAX_ARGC_O(MO), .TIMEOUT_W(TW)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .tbl_in_addr(tbl_in_addr), .argc_i(argc_i),
        .tbl_out_addr(tbl_out_addr), .argc_o(argc_o), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .dma_rx_address(dma_rx_address), .dma_rx_start(dma_rx_start),
        .dma_rx_data(dma_rx_data), .dma_tx_address(dma_tx_address), .dma_tx_start(dma_tx_start),
        .dma_tx_data(dma_tx_data), .dma_done(dma_done), .dma_idle(dma_idle), .dma_error(dma_error),
        .core_start(core_start), .core_op(core_op), .core_args(core_args), .core_done(core_done),
        .core_res(core_res)
    );

    int n_chk, n_err;
    logic [DW-1:0] rd_mem [0:15];
    int rd_cnt, err_at, cur_ai;
    bit hang;
    logic [31:0] rd_addr_q [$];
    logic [31:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    int rx_cnt, tx_cnt, cs_cnt;

    logic [31:0] r_tin, r_tout, r_cmd;
    logic [31:0] r_pi [MI];
    logic [31:0] r_po [MO];
    logic [DW-1:0] r_op [MI];
    logic [DW-1:0] r_slot [MI];
    int r_ai, r_ao, r_err_at;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_wide();
        logic [383:0] t;
        for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom();
        return t[DW-1:0];
    endfunction

    // DMA responder: logs each request, answers after 0..2 cycles from the prepared read image
    initial begin
        bit is_rd;
        dma_done = 1'b0; dma_error = 1'b0; dma_idle = 1'b1; dma_rx_data = '0;
        forever begin
            @(posedge clk); #1;
            dma_done = 1'b0; dma_error = 1'b0;
            dma_idle = ($urandom_range(3) != 0);
            if (dma_rx_start || dma_tx_start) begin
                is_rd = dma_rx_start;
                if (is_rd) rd_addr_q.push_back(dma_rx_address);
                else begin
                    wr_addr_q.push_back(dma_tx_address);
                    wr_data_q.push_back(dma_tx_data);
                end
                if (!hang) begin
                    repeat ($urandom_range(2)) begin @(posedge clk); #1; end
                    dma_done = 1'b1;
                    if (is_rd) begin
                        dma_rx_data = rd_mem[rd_cnt & 15];
                        dma_error = (rd_cnt == err_at);
                        rd_cnt++;
                    end
                end
            end
        end
    end

    // Core: result k = operand k (operand 0 when k is beyond argc_i) plus k
    initial begin
        core_done = 1'b0; core_res = '0;
        forever begin
            @(posedge clk); #1;
            core_done = 1'b0;
            if (core_start) begin
                repeat (1 + $urandom_range(1)) begin @(posedge clk); #1; end
                for (int k = 0; k < MO; k++)
                    core_res[k*DW +: DW] = ((k < cur_ai) ? core_args[k*DW +: DW] : core_args[0 +: DW]) + DW'(k);
                core_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (dma_rx_start) rx_cnt++;
        if (dma_tx_start) tx_cnt++;
        if (core_start)   cs_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic set_op(input int j, input logic [DW-1:0] v);
        r_op[j] = v;
        rd_mem[1+j] = v;
    endtask

    task automatic setup(input int ai, input int ao, input int ea);
        logic [DW-1:0] t;
        r_ai = ai; r_ao = ao; r_err_at = ea; cur_ai = ai;
        r_tin = $urandom(); r_tout = $urandom();
        for (int j = 0; j < MI; j++) r_pi[j] = $urandom();
        for (int j = 0; j < MO; j++) r_po[j] = $urandom();
        for (int j = 0; j < MI; j++) r_op[j] = rand_wide();
        t = rand_wide();
        for (int j = 0; j < MI; j++) t[DW-1-32*j -: 32] = r_pi[j];
        rd_mem[0] = t;
        for (int j = 0; j < ai; j++) rd_mem[1+j] = r_op[j];
        t = rand_wide();
        for (int j = 0; j < MO; j++) t[DW-1-32*j -: 32] = r_po[j];
        rd_mem[ai+1] = t;
        rd_cnt = 0; err_at = ea;
        rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        rx_cnt = 0; tx_cnt = 0; cs_cnt = 0;
        tbl_in_addr = r_tin; tbl_out_addr = r_tout;
        argc_i = ai; argc_o = ao;
    endtask

    task automatic finish_cmd();
        int n;
        int ok_args;
        logic [31:0] ea;
        logic [DW-1:0] er;
        n = 0;
        while (!(done || err) && n < 3000) begin @(negedge clk); n++; end
        chk("end_reached", DW'(done | err), DW'(1));
        if (r_err_at < 0) begin
            chk("done", DW'(done), DW'(1));
            chk("err", DW'(err), DW'(0));
            chk("core_op", DW'(core_op), DW'(r_cmd));
            chk("rx_starts", DW'(rx_cnt), DW'(r_ai + 2));
            chk("tx_starts", DW'(tx_cnt), DW'(r_ao));
            chk("core_start_cycles", DW'(cs_cnt), DW'(1));
            chk("rx_log_len", DW'(rd_addr_q.size()), DW'(r_ai + 2));
            chk("tx_log_len", DW'(wr_addr_q.size()), DW'(r_ao));
            for (int k = 0; k < r_ai + 2; k++) begin
                ea = (k == 0) ? r_tin : (k == r_ai + 1) ? r_tout : r_pi[k-1];
                if (k < rd_addr_q.size()) chk("rx_addr", DW'(rd_addr_q[k]), DW'(ea));
            end
            for (int k = 0; k < r_ao; k++) begin
                er = ((k < r_ai) ? r_op[k] : r_op[0]) + DW'(k);
                if (k < wr_addr_q.size()) begin
                    chk("tx_addr", DW'(wr_addr_q[k]), DW'(r_po[k]));
                    chk("tx_data", wr_data_q[k], er);
                end
            end
            ok_args = r_ai;
        end else begin
            chk("err", DW'(err), DW'(1));
            chk("err_code_dma", DW'(err_code), DW'(2));
            chk("no_core_start", DW'(cs_cnt), DW'(0));
            chk("rx_starts_err", DW'(rx_cnt), DW'(r_err_at + 1));
            ok_args = r_err_at - 1;
        end
        for (int j = 0; j < ok_args; j++) r_slot[j] = r_op[j];
        for (int j = 0; j < MI; j++) chk("core_arg", core_args[j*DW +: DW], r_slot[j]);
        cmd = '0;
        @(negedge clk);
        chk("idle_done", DW'(done), DW'(0));
        chk("idle_err", DW'(err), DW'(0));
        chk("idle_err_code", DW'(err_code), DW'(0));
        chk("idle_busy", DW'(busy), DW'(0));
    endtask

    task automatic bad_argc(input int ai, input int ao);
        setup(1, 1, -1);
        argc_i = ai; argc_o = ao;
        cmd = 32'h7;
        @(negedge clk);
        chk("bad_argc_err", DW'(err), DW'(1));
        chk("bad_argc_code", DW'(err_code), DW'(1));
        chk("bad_argc_busy", DW'(busy), DW'(0));
        @(negedge clk);
        chk("bad_argc_no_rx", DW'(rx_cnt), DW'(0));
        cmd = '0;
        @(negedge clk);
        chk("bad_argc_clear_err", DW'(err), DW'(0));
        chk("bad_argc_clear_code", DW'(err_code), DW'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, DW'(busy), '0);
        chk({tag, "_done"}, DW'(done), '0);
        chk({tag, "_err"}, DW'(err), '0);
        chk({tag, "_err_code"}, DW'(err_code), '0);
        chk({tag, "_rx_start"}, DW'(dma_rx_start), '0);
        chk({tag, "_tx_start"}, DW'(dma_tx_start), '0);
        chk({tag, "_rx_addr"}, DW'(dma_rx_address), '0);
        chk({tag, "_tx_addr"}, DW'(dma_tx_address), '0);
        chk({tag, "_tx_data"}, dma_tx_data, '0);
        chk({tag, "_core_start"}, DW'(core_start), '0);
        chk({tag, "_core_op"}, DW'(core_op), '0);
        for (int j = 0; j < MI; j++) chk({tag, "_core_arg"}, core_args[j*DW +: DW], '0);
    endtask

    task automatic reset_test();
        int n;
        setup(2, 2, -1);
        r_cmd = 32'h1; cmd = 32'h1;
        n = 0;
        while (!core_start && n < 1000) begin @(posedge clk); #1; n++; end
        chk("saw_core_start", DW'(core_start), DW'(1));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        for (int j = 0; j < MI; j++) r_slot[j] = '0;
        repeat (3) @(negedge clk);
        setup(3, 2, -1);
        reset = 1'b0;
        finish_cmd();
    endtask

    initial begin
        int ai, ao;
        int n;
        n_chk = 0; n_err = 0;
        reset = 1'b1; cmd = '0; tbl_in_addr = '0; tbl_out_addr = '0; argc_i = '0; argc_o = '0;
        hang = 1'b0; err_at = -1; cur_ai = 1; rd_cnt = 0;
        rx_cnt = 0; tx_cnt = 0; cs_cnt = 0;
        for (int j = 0; j < MI; j++) r_slot[j] = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        setup(3, 1, -1);
        set_op(0, DW'(32'hA)); set_op(1, DW'(32'hB)); set_op(2, DW'(32'hC));
        r_cmd = 32'h1; cmd = r_cmd;
        finish_cmd();

        setup(7, 3, -1);
        r_cmd = $urandom() | 32'h1; cmd = r_cmd;
        finish_cmd();

        bad_argc(8, 1);
        bad_argc(3, 0);
        bad_argc(0, 2);
        bad_argc(1, 4);

        setup(3, 1, 2);
        r_cmd = 32'h5; cmd = r_cmd;
        finish_cmd();

        for (int i = 0; i < 10; i++) begin
            ai = $urandom_range(7, 1);
            ao = $urandom_range(3, 1);
            setup(ai, ao, -1);
            r_cmd = $urandom() | 32'h1; cmd = r_cmd;
            finish_cmd();
        end

        reset_test();

`ifdef DMA_TIMEOUT_EN
        setup(1, 1, -1);
        hang = 1'b1;
        cmd = 32'h3;
        n = 0;
        while (!err && n < 100) begin @(negedge clk); n++; end
        chk("timeout_err", DW'(err), DW'(1));
        chk("timeout_code", DW'(err_code), DW'(3));
        cmd = '0;
        @(negedge clk);
        hang = 1'b0;
        chk("timeout_clear", DW'(err_code), DW'(0));
`else
        n = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
